// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: feeds an external 1-bit ALU LSB first over WIDTH
// cycles and reassembles the result word, carry and error status.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds a registered Zero output.
module alu_serial_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A_word,
  input  logic [WIDTH-1:0] B_word,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic [2:0]       ALU_Mode,
  output logic             ALU_A,
  output logic             ALU_B,
  output logic             ALU_Cin,
  input  logic             ALU_X,
  input  logic             ALU_Cout
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic             Zero
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_XNOR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  // Next-state and next-register logic. Operand shifters drain to zero by the
  // end of RUN, so the ALU operand pins are naturally 0 outside RUN.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    cin_d   = 1'b0;
    res_d   = res_q;
    carry_d = carry_q;
    err_d   = err_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          op_d    = Op;
          cnt_d   = '0;
          res_d   = '0;
          carry_d = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero_d  = 1'b0;
`endif
          if (Op <= OP_XNOR) begin
            state_d = RUN;
            a_d     = A_word;
            b_d     = B_word;
            err_d   = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            a_d     = '0;
            b_d     = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {ALU_X, res_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          carry_d = (op_q == OP_ADD) ? ALU_Cout : 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero_d  = (res_d == '0);
`endif
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
          cin_d  = (op_q == OP_ADD) ? ALU_Cout : 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign Result   = res_q;
  assign Carry    = carry_q;
  assign ALU_Mode = op_q;
  assign ALU_A    = a_q[0];
  assign ALU_B    = b_q[0];
  assign ALU_Cin  = cin_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign Zero     = zero_q;
`endif

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural 1-bit ALU attached.
module tb_alu_serial_sequencer;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] A_word;
  logic [W-1:0] B_word;
  logic         Busy;
  logic         Done;
  logic         Err;
  logic [W-1:0] Result;
  logic         Carry;
  logic [2:0]   ALU_Mode;
  logic         ALU_A;
  logic         ALU_B;
  logic         ALU_Cin;
  logic         ALU_X;
  logic         ALU_Cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic         Zero;
`endif

  int errors = 0;
  int checks = 0;
  int done_at;
  int busy_cnt;
  bit cin_seen;
  bit outside_nz;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
    .A_word(A_word), .B_word(B_word),
    .Busy(Busy), .Done(Done), .Err(Err), .Result(Result), .Carry(Carry),
    .ALU_Mode(ALU_Mode), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Cin(ALU_Cin),
    .ALU_X(ALU_X), .ALU_Cout(ALU_Cout)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .Zero(Zero)
`endif
  );

  always #5 CLK = ~CLK;

  // 1-bit ALU model: full adder for ADD, bitwise logic otherwise.
  always_comb begin
    ALU_X    = 1'b0;
    ALU_Cout = 1'b0;
    case (ALU_Mode)
      3'd0: begin
        ALU_X    = ALU_A ^ ALU_B ^ ALU_Cin;
        ALU_Cout = (ALU_A & ALU_B) | (ALU_Cin & (ALU_A ^ ALU_B));
      end
      3'd1: ALU_X = ALU_A & ALU_B;
      3'd2: ALU_X = ALU_A | ALU_B;
      3'd3: ALU_X = ALU_A ^ ALU_B;
      3'd4: ALU_X = ~(ALU_A ^ ALU_B);
      default: ALU_X = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request and follow it until Done (bounded); ends in the Done cycle.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit clr_ops);
    Start = 1'b1; Op = op; A_word = a; B_word = b;
    step();
    Start = 1'b0;
    if (clr_ops) begin A_word = '0; B_word = '0; end
    done_at = -1; busy_cnt = 0; cin_seen = 1'b0; outside_nz = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (Busy) busy_cnt++;
      if (Busy && ALU_Cin) cin_seen = 1'b1;
      if (!Busy && (ALU_A || ALU_B || ALU_Cin)) outside_nz = 1'b1;
      if (Done) begin done_at = j; break; end
      step();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; Op = 3'd0; A_word = '0; B_word = '0;
    #12;
    checks++;
    if ({Busy, Done, Err, Result, Carry, ALU_Mode, ALU_A, ALU_B, ALU_Cin} !== '0)
      begin errors++; $display("FAIL reset_outputs: got %b required 0",
        {Busy, Done, Err, Result, Carry, ALU_Mode, ALU_A, ALU_B, ALU_Cin}); end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_add();
    run_op(3'd0, 8'hFF, 8'h01, 1'b0);
    checks++; if (done_at !== 8) begin errors++; $display("FAIL add_latency: got %0d required 8", done_at); end
    checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL add_busy_cycles: got %0d required 8", busy_cnt); end
    checks++; if (Result !== 8'h00) begin errors++; $display("FAIL add_result: got %h required 00", Result); end
    checks++; if (Carry !== 1'b1) begin errors++; $display("FAIL add_carry: got %b required 1", Carry); end
    checks++; if (outside_nz !== 1'b0) begin errors++; $display("FAIL add_pins_idle: got %b required 0", outside_nz); end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL add_zero: got %b required 1", Zero); end
`endif
    step();
  endtask

  task automatic test_logic_ops();
    run_op(3'd1, 8'hF0, 8'h3C, 1'b0);
    checks++; if (Result !== 8'h30) begin errors++; $display("FAIL and_result: got %h required 30", Result); end
    checks++; if (Carry !== 1'b0) begin errors++; $display("FAIL and_carry: got %b required 0", Carry); end
    checks++; if (cin_seen !== 1'b0) begin errors++; $display("FAIL and_cin: got %b required 0", cin_seen); end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL and_zero: got %b required 0", Zero); end
`endif
    step();
    run_op(3'd4, 8'hA5, 8'h0F, 1'b0);
    checks++; if (Result !== 8'h55) begin errors++; $display("FAIL xnor_result: got %h required 55", Result); end
    checks++; if (done_at !== 8) begin errors++; $display("FAIL xnor_latency: got %0d required 8", done_at); end
    step();
  endtask

  task automatic test_illegal();
    run_op(3'd6, 8'hFF, 8'hFF, 1'b0);
    checks++; if (done_at !== 0) begin errors++; $display("FAIL illegal_latency: got %0d required 0", done_at); end
    checks++; if (Err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b required 1", Err); end
    checks++; if ({Result, Carry} !== '0) begin errors++; $display("FAIL illegal_result: got %h/%b required 0/0", Result, Carry); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL illegal_busy: got %0d required 0", busy_cnt); end
    checks++; if (outside_nz !== 1'b0) begin errors++; $display("FAIL illegal_pins: got %b required 0", outside_nz); end
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if ({Err, ALU_Mode, Result, ALU_A, ALU_B, ALU_Cin, Done} !== {1'b1, 3'd6, 8'h00, 4'b0000})
        begin errors++; $display("FAIL illegal_hold: err=%b mode=%0d result=%h pins=%b%b%b done=%b required 1/6/00/000/0",
          Err, ALU_Mode, Result, ALU_A, ALU_B, ALU_Cin, Done); end
    end
  endtask

  task automatic test_back_to_back();
    Start = 1'b1; Op = 3'd0; A_word = 8'h12; B_word = 8'h34;
    step();
    for (int j = 0; j <= 10; j++) begin
      checks++;
      if (j < 8) begin
        if (!(Busy === 1'b1 && Done === 1'b0)) begin errors++;
          $display("FAIL b2b_run j=%0d: busy=%b done=%b required 1/0", j, Busy, Done); end
      end else if (j == 8) begin
        if ({Done, Err, Result, Carry} !== {1'b1, 1'b0, 8'h46, 1'b0}) begin errors++;
          $display("FAIL b2b_first: done=%b err=%b result=%h carry=%b required 1/0/46/0", Done, Err, Result, Carry); end
      end else if (j == 9) begin
        if ({Busy, Done} !== 2'b00) begin errors++;
          $display("FAIL b2b_gap: busy=%b done=%b required 0/0", Busy, Done); end
      end else begin
        if (Busy !== 1'b1) begin errors++;
          $display("FAIL b2b_reaccept: busy=%b required 1", Busy); end
      end
      step();
    end
    Start = 1'b0;
    done_at = -1;
    for (int j = 0; j < 20; j++) begin
      if (Done) begin done_at = j; break; end
      step();
    end
    checks++;
    if (done_at < 0 || Result !== 8'h46) begin errors++;
      $display("FAIL b2b_second: done_at=%0d result=%h required done/46", done_at, Result); end
    step();
  endtask

  task automatic test_reset_midrun();
    int done_seen;
    Start = 1'b1; Op = 3'd0; A_word = 8'h0F; B_word = 8'h01;
    step();
    Start = 1'b0;
    repeat (4) step();
    RST = 1'b1;
    #1;
    checks++;
    if ({Busy, Done, Err, Result, Carry, ALU_Mode, ALU_A, ALU_B, ALU_Cin} !== '0)
      begin errors++; $display("FAIL midrun_reset: got %b required 0",
        {Busy, Done, Err, Result, Carry, ALU_Mode, ALU_A, ALU_B, ALU_Cin}); end
    done_seen = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      if (Done) done_seen++;
    end
    RST = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (Done) done_seen++;
      step();
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d required 0", done_seen); end
    run_op(3'd0, 8'h0F, 8'h01, 1'b0);
    checks++; if (Result !== 8'h10) begin errors++; $display("FAIL midrun_rerun: got %h required 10", Result); end
    checks++; if (done_at !== 8) begin errors++; $display("FAIL midrun_rerun_latency: got %0d required 8", done_at); end
    repeat (3) step();
    checks++; if ({Result, Carry} !== {8'h10, 1'b0}) begin errors++; $display("FAIL result_hold: got %h/%b required 10/0", Result, Carry); end
  endtask

  task automatic test_operand_change();
    run_op(3'd2, 8'h81, 8'h42, 1'b1);
    checks++; if (Result !== 8'hC3) begin errors++; $display("FAIL operand_change: got %h required c3", Result); end
    step();
  endtask

  task automatic test_first_edge_after_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
    run_op(3'd3, 8'hF0, 8'h33, 1'b0);
    checks++; if (done_at !== 8 || Result !== 8'hC3) begin errors++;
      $display("FAIL post_reset_accept: done_at=%0d result=%h required 8/c3", done_at, Result); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic_ops();
    test_illegal();
    test_back_to_back();
    test_reset_midrun();
    test_operand_change();
    test_first_edge_after_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_serial_sequencer.md
ALU_SERIAL_SEQUENCER -- requirements
Module: alu_serial_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, meaning the operand/result bit count (legal range 2..32).
REQ-002 The block SHALL have the following ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  reset, asynchronous, active-high.
- Start  input  1  request to run one operation.
- Op  input  3  opcode: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 XNOR, 5-7 illegal.
- A_word  input  WIDTH  operand A.
- B_word  input  WIDTH  operand B.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle completion pulse.
- Err  output  1  illegal-opcode flag.
- Result  output  WIDTH  result word.
- Carry  output  1  final carry (ADD only).
- ALU_Mode  output  3  opcode driven to the 1-bit ALU.
- ALU_A  output  1  operand A bit driven to the ALU.
- ALU_B  output  1  operand B bit driven to the ALU.
- ALU_Cin  output  1  carry-in driven to the ALU.
- ALU_X  input  1  result bit returned by the ALU (combinational).
- ALU_Cout  input  1  carry bit returned by the ALU (combinational).
REQ-003 CLK and RST SHALL be the only clock and reset; RST SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have three states, IDLE, RUN and DONE, with the following transitions:
- IDLE->RUN on Start=1 with a legal Op.
- IDLE->DONE on Start=1 with an illegal Op.
- RUN->DONE after WIDTH bit cycles.
- DONE->IDLE unconditionally.
REQ-005 On acceptance, the block SHALL register Op, A_word and B_word into internal shift registers and clear the bit counter and the carry register.
REQ-006 In RUN, ALU_A and ALU_B SHALL present operand bit i at bit cycle i, LSB first (i=0..WIDTH-1), and ALU_Mode SHALL equal the registered Op.
REQ-007 ALU_Cin SHALL equal the carry register when Op=ADD and SHALL be 0 otherwise; the carry register SHALL load ALU_Cout each bit cycle when Op=ADD.
REQ-008 At each RUN rising edge, the block SHALL shift ALU_X into Result bit i; the ALU is treated as zero-latency combinational logic.
REQ-009 Latency SHALL be as follows: if Start is accepted at edge k, Done=1 during the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance.
REQ-010 Busy SHALL be 1 in RUN and 0 in IDLE and DONE; Done SHALL be 1 only in DONE.
REQ-011 Carry SHALL equal the final ALU_Cout for ADD and SHALL be 0 for all other opcodes.
REQ-012 For an illegal Op, the block SHALL NOT drive a RUN sequence; Done and Err SHALL both be 1 in the following cycle, and Result and Carry SHALL be 0.
REQ-013 Err SHALL hold its value until the next accepted Start.
REQ-014 Result and Carry SHALL hold their values from DONE until the next accepted Start; they SHALL NOT change while in IDLE.
REQ-015 Start SHALL be ignored in RUN and DONE; a Start asserted in the DONE cycle SHALL be lost, and a new request SHALL be accepted only from IDLE.
REQ-016 Operand inputs SHALL be don't-care after acceptance; changes during RUN SHALL NOT affect the operation.
REQ-017 The bit counter SHALL be ceil(log2(WIDTH)) bits wide, and the transition to DONE SHALL occur on count WIDTH-1 without wrap.
REQ-018 Outside RUN, ALU_A, ALU_B and ALU_Cin SHALL be 0 and ALU_Mode SHALL hold its last registered value.

Reset
REQ-019 While RST=1, the block SHALL be forced to IDLE, and Busy, Done, Err, Result, Carry, ALU_Mode, ALU_A, ALU_B and ALU_Cin SHALL all be 0.
REQ-020 An RST asserted mid-RUN SHALL abort the operation immediately, with no Done pulse and a zero Result.
REQ-021 After RST deasserts, Start SHALL be accepted on the first rising edge.

Configuration
REQ-022 When ALU_SEQ_ZERO_FLAG_EN is defined, the block SHALL add an output port Zero (1 bit), registered and set in DONE to 1 when Result==0 after a legal operation, 0 otherwise; Zero SHALL be held like Result and reset to 0.
REQ-023 When ALU_SEQ_ZERO_FLAG_EN is undefined, the port Zero and all of its logic SHALL be absent.

Verification
REQ-024 The bench SHALL cover the following directed scenarios, with a bit-accurate 1-bit ALU model attached:
- ADD, A=8'hFF, B=8'h01, one-cycle Start -> Done at acceptance+9 cycles, Result=8'h00, Carry=1, Busy high for exactly 8 cycles (Zero=1 if enabled).
- AND, A=8'hF0, B=8'h3C -> Result=8'h30, Carry=0, ALU_Cin=0 throughout RUN; XNOR, A=8'hA5, B=8'h0F -> Result=8'h55.
- Op=6 -> Done and Err high one cycle after acceptance, Result=0, ALU_A, ALU_B and ALU_Cin remain 0 throughout.
- Start held high continuously with ADD 8'h12+8'h34 -> first op Result=8'h46; next acceptance occurs 2 cycles after the Done cycle, and Start is ignored during RUN and DONE.
- RST pulsed during bit cycle 4 of ADD 8'h0F+8'h01 -> all outputs 0 asynchronously, no Done pulse; a following ADD 8'h0F+8'h01 -> Result=8'h10.
- A_word and B_word changed to 8'h00 during RUN of OR 8'h81|8'h42 -> Result=8'hC3.
